// File: rtl/fl_pac_fifo_if.sv
// FrameLink bus: data word, valid-byte index, active-low delimiters and handshake.
// The master drives the word and SRC_RDY_N; the slave answers with DST_RDY_N.
interface fl_pac_fifo_if #(
    parameter int DATA_WIDTH = 64
);
    localparam int REM_WIDTH = $clog2(DATA_WIDTH / 8);

    logic [DATA_WIDTH-1:0] DATA;
    logic [REM_WIDTH-1:0]  REM;
    logic                  SOF_N;
    logic                  SOP_N;
    logic                  EOP_N;
    logic                  EOF_N;
    logic                  SRC_RDY_N;
    logic                  DST_RDY_N;

    modport master (
        output DATA, REM, SOF_N, SOP_N, EOP_N, EOF_N, SRC_RDY_N,
        input  DST_RDY_N
    );

    modport slave (
        input  DATA, REM, SOF_N, SOP_N, EOP_N, EOF_N, SRC_RDY_N,
        output DST_RDY_N
    );
endinterface

// File: rtl/fl_pac_fifo.sv
// FrameLink packet FIFO: store-and-forward on whole frames, falling back to
// cut-through when a single frame is larger than the storage.
module fl_pac_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 64,
    localparam int REM_WIDTH = $clog2(DATA_WIDTH / 8),
    localparam int CNT_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                 CLK,
    input  logic                 RESET_N,
    fl_pac_fifo_if.slave         RX,
    fl_pac_fifo_if.master        TX,
    output logic [CNT_WIDTH-1:0] FRAME_CNT,
    output logic [CNT_WIDTH-1:0] WORD_CNT,
    output logic                 EMPTY,
    output logic                 FULL
);
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int ENT_WIDTH = DATA_WIDTH + REM_WIDTH + 4;
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    typedef enum logic {SAF, CT} state_t;

    state_t                 state, state_nxt;
    logic [ENT_WIDTH-1:0]   mem [DEPTH];
    logic [ENT_WIDTH-1:0]   head;
    logic [PTR_WIDTH-1:0]   wr_ptr, rd_ptr;
    logic [CNT_WIDTH-1:0]   word_cnt, word_cnt_nxt;
    logic [CNT_WIDTH-1:0]   frame_cnt, frame_cnt_nxt;
    logic                   rx_dst_rdy_n, tx_src_rdy_n;
    logic                   acc, xfer, eof_in, eof_out;

    assign acc     = !RX.SRC_RDY_N && !rx_dst_rdy_n;
    assign xfer    = !tx_src_rdy_n && !TX.DST_RDY_N;
    assign eof_in  = acc && !RX.EOF_N;
    assign eof_out = xfer && !head[0];

    always_ff @(posedge CLK) begin
        if (acc) begin
            mem[wr_ptr] <= {RX.DATA, RX.REM, RX.SOF_N, RX.SOP_N, RX.EOP_N, RX.EOF_N};
        end
    end

    // First-word fall-through: the head entry is always on the TX bus.
    assign head = mem[rd_ptr];
    assign {TX.DATA, TX.REM, TX.SOF_N, TX.SOP_N, TX.EOP_N, TX.EOF_N} = head;
    assign TX.SRC_RDY_N = tx_src_rdy_n;
    assign RX.DST_RDY_N = rx_dst_rdy_n;

    assign WORD_CNT  = word_cnt;
    assign FRAME_CNT = frame_cnt;
    assign EMPTY     = (word_cnt == '0);
    assign FULL      = (word_cnt == CNT_FULL);

    always_comb begin
        word_cnt_nxt  = word_cnt;
        frame_cnt_nxt = frame_cnt;
        if (acc && !xfer) begin
            word_cnt_nxt = word_cnt + CNT_ONE;
        end else if (!acc && xfer) begin
            word_cnt_nxt = word_cnt - CNT_ONE;
        end
        if (eof_in && !eof_out) begin
            frame_cnt_nxt = frame_cnt + CNT_ONE;
        end else if (!eof_in && eof_out) begin
            frame_cnt_nxt = frame_cnt - CNT_ONE;
        end
    end

    always_comb begin
        tx_src_rdy_n = 1'b1;
        unique case (state)
            SAF: tx_src_rdy_n = (frame_cnt == '0);
            CT:  tx_src_rdy_n = (word_cnt == '0);
            default: tx_src_rdy_n = 1'b1;
        endcase
    end

    // A full FIFO with no complete frame can only drain by streaming the
    // oversized frame out before its EOF has arrived.
    always_comb begin
        state_nxt = state;
        unique case (state)
            SAF: if (FULL && frame_cnt == '0) state_nxt = CT;
            CT:  if (eof_out) state_nxt = SAF;
            default: state_nxt = SAF;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state        <= SAF;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            word_cnt     <= '0;
            frame_cnt    <= '0;
            rx_dst_rdy_n <= 1'b1;
        end else begin
            state        <= state_nxt;
            word_cnt     <= word_cnt_nxt;
            frame_cnt    <= frame_cnt_nxt;
            rx_dst_rdy_n <= (word_cnt_nxt == CNT_FULL);
            if (acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (xfer) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end
endmodule

// File: tb/tb_fl_pac_fifo.sv
// Bench for fl_pac_fifo: queue-based reference model compared every cycle,
// directed frame scenarios with literal checkpoints, and random traffic.
module tb_fl_pac_fifo;
    localparam int DW    = 64;
    localparam int DEPTH = 64;
    localparam int CW    = 7;

    typedef struct {
        logic [63:0] data;
        logic [2:0]  rem;
        logic        sof_n, sop_n, eop_n, eof_n;
    } ent_t;

    logic CLK = 1'b0;
    logic RESET_N = 1'b0;
    logic [CW-1:0] frame_cnt, word_cnt;
    logic empty, full;

    fl_pac_fifo_if #(.DATA_WIDTH(DW)) rx_if ();
    fl_pac_fifo_if #(.DATA_WIDTH(DW)) tx_if ();

    fl_pac_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .CLK(CLK),
        .RESET_N(RESET_N),
        .RX(rx_if),
        .TX(tx_if),
        .FRAME_CNT(frame_cnt),
        .WORD_CNT(word_cnt),
        .EMPTY(empty),
        .FULL(full)
    );

    initial forever #5 CLK = ~CLK;

    int total = 0;
    int bad = 0;

    ent_t mq[$];
    ent_t stim[$];
    bit   m_ct = 1'b0;
    bit   m_rx_rdy_n = 1'b1;
    bit   last_acc = 1'b0;
    int   bp_mode = 1;
    int   src_pct = 100;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eof_count();
        int n = 0;
        foreach (mq[i]) if (mq[i].eof_n == 1'b0) n++;
        return n;
    endfunction

    function automatic bit exp_src_n();
        if (m_ct) return (mq.size() == 0);
        return (eof_count() == 0);
    endfunction

    // Reference model: a queue of stored words plus a cut-through flag.
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            mq.delete();
            m_ct       = 1'b0;
            m_rx_rdy_n = 1'b1;
            last_acc   = 1'b0;
        end else begin
            bit acc, xfer, head_eof;
            ent_t e;
            acc  = !rx_if.SRC_RDY_N && !m_rx_rdy_n;
            xfer = !exp_src_n() && !tx_if.DST_RDY_N;
            head_eof = (mq.size() > 0) && (mq[0].eof_n == 1'b0);
            if (!m_ct && mq.size() == DEPTH && eof_count() == 0) m_ct = 1'b1;
            else if (m_ct && xfer && head_eof) m_ct = 1'b0;
            if (xfer) void'(mq.pop_front());
            if (acc) begin
                e.data  = rx_if.DATA;
                e.rem   = rx_if.REM;
                e.sof_n = rx_if.SOF_N;
                e.sop_n = rx_if.SOP_N;
                e.eop_n = rx_if.EOP_N;
                e.eof_n = rx_if.EOF_N;
                mq.push_back(e);
            end
            m_rx_rdy_n = (mq.size() == DEPTH);
            last_acc   = acc;
        end
    end

    always @(negedge CLK) begin
        chk("tx_src_rdy_n", 64'(tx_if.SRC_RDY_N), 64'(exp_src_n()));
        chk("rx_dst_rdy_n", 64'(rx_if.DST_RDY_N), 64'(m_rx_rdy_n));
        chk("word_cnt", 64'(word_cnt), 64'(mq.size()));
        chk("frame_cnt", 64'(frame_cnt), 64'(eof_count()));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("full", 64'(full), 64'(mq.size() == DEPTH));
        if (mq.size() > 0) begin
            chk("tx_data", tx_if.DATA, mq[0].data);
            chk("tx_rem", 64'(tx_if.REM), 64'(mq[0].rem));
            chk("tx_delims", 64'({tx_if.SOF_N, tx_if.SOP_N, tx_if.EOP_N, tx_if.EOF_N}),
                64'({mq[0].sof_n, mq[0].sop_n, mq[0].eop_n, mq[0].eof_n}));
        end
    end

    task automatic push_frame(int len, logic [2:0] rem);
        for (int i = 0; i < len; i++) begin
            ent_t e;
            e.data  = {$urandom, $urandom};
            e.rem   = rem;
            e.sof_n = (i != 0);
            e.sop_n = (i != 0);
            e.eop_n = (i != len - 1);
            e.eof_n = (i != len - 1);
            stim.push_back(e);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #2;
        if (last_acc && stim.size() > 0) void'(stim.pop_front());
        if (stim.size() > 0 && $urandom_range(99) < src_pct) begin
            rx_if.DATA      = stim[0].data;
            rx_if.REM       = stim[0].rem;
            rx_if.SOF_N     = stim[0].sof_n;
            rx_if.SOP_N     = stim[0].sop_n;
            rx_if.EOP_N     = stim[0].eop_n;
            rx_if.EOF_N     = stim[0].eof_n;
            rx_if.SRC_RDY_N = 1'b0;
        end else begin
            rx_if.SRC_RDY_N = 1'b1;
        end
        case (bp_mode)
            0:       tx_if.DST_RDY_N = 1'b0;
            1:       tx_if.DST_RDY_N = 1'b1;
            default: tx_if.DST_RDY_N = 1'($urandom_range(1));
        endcase
    endtask

    task automatic run(int n);
        repeat (n) step();
    endtask

    task automatic drain(string name, int limit);
        int c = 0;
        while ((stim.size() > 0 || mq.size() > 0) && c < limit) begin
            step();
            c++;
        end
        chk({name, "_drain_in_time"}, 64'(c < limit), 64'd1);
    endtask

    task automatic fill_to(string name, int n, int limit);
        int c = 0;
        while (mq.size() < n && c < limit) begin
            step();
            c++;
        end
        chk({name, "_fill_in_time"}, 64'(c < limit), 64'd1);
    endtask

    initial begin
        rx_if.DATA = '0; rx_if.REM = '0;
        rx_if.SOF_N = 1'b1; rx_if.SOP_N = 1'b1; rx_if.EOP_N = 1'b1; rx_if.EOF_N = 1'b1;
        rx_if.SRC_RDY_N = 1'b1;
        tx_if.DST_RDY_N = 1'b1;

        // reset state
        #12;
        chk("rst_rx_dst_rdy_n", 64'(rx_if.DST_RDY_N), 64'd1);
        chk("rst_tx_src_rdy_n", 64'(tx_if.SRC_RDY_N), 64'd1);
        chk("rst_empty", 64'(empty), 64'd1);
        chk("rst_full", 64'(full), 64'd0);
        #10 RESET_N = 1'b1;
        step();
        chk("post_rst_rx_dst_rdy_n", 64'(rx_if.DST_RDY_N), 64'd0);
        chk("post_rst_word_cnt", 64'(word_cnt), 64'd0);

        // single 3-word frame, REM=5
        bp_mode = 0;
        push_frame(3, 3'd5);
        step();
        run(2);
        chk("f3_wait_tx_src_rdy_n", 64'(tx_if.SRC_RDY_N), 64'd1);
        step();
        chk("f3_tx_src_rdy_n", 64'(tx_if.SRC_RDY_N), 64'd0);
        chk("f3_frame_cnt", 64'(frame_cnt), 64'd1);
        chk("f3_word_cnt", 64'(word_cnt), 64'd3);
        chk("f3_rem", 64'(tx_if.REM), 64'd5);
        chk("f3_sof_n", 64'(tx_if.SOF_N), 64'd0);
        run(3);
        chk("f3_done_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("f3_done_word_cnt", 64'(word_cnt), 64'd0);

        // fill with 8 frames of 8 words
        bp_mode = 1;
        for (int f = 0; f < 8; f++) push_frame(8, 3'($urandom));
        fill_to("full", 64, 200);
        chk("full_full", 64'(full), 64'd1);
        chk("full_rx_dst_rdy_n", 64'(rx_if.DST_RDY_N), 64'd1);
        chk("full_frame_cnt", 64'(frame_cnt), 64'd8);
        bp_mode = 0;
        step();
        bp_mode = 1;
        step();
        chk("full_one_out_word_cnt", 64'(word_cnt), 64'd63);
        chk("full_one_out_rx_dst_rdy_n", 64'(rx_if.DST_RDY_N), 64'd0);
        bp_mode = 0;
        drain("full", 500);

        // 100-word frame forces cut-through
        bp_mode = 1;
        push_frame(100, 3'd2);
        fill_to("ct", 64, 300);
        chk("ct_pre_tx_src_rdy_n", 64'(tx_if.SRC_RDY_N), 64'd1);
        chk("ct_pre_frame_cnt", 64'(frame_cnt), 64'd0);
        step();
        chk("ct_tx_src_rdy_n", 64'(tx_if.SRC_RDY_N), 64'd0);
        bp_mode = 0;
        drain("ct", 1000);
        push_frame(3, 3'd1);
        run(3);
        chk("ct_back_saf_tx_src_rdy_n", 64'(tx_if.SRC_RDY_N), 64'd1);
        drain("ct_next", 100);

        // simultaneous EOF accept and EOF transfer with two frames stored
        bp_mode = 1;
        push_frame(1, 3'd3);
        push_frame(1, 3'd4);
        fill_to("simul", 2, 50);
        push_frame(1, 3'd6);
        bp_mode = 0;
        step();
        step();
        chk("simul_frame_cnt", 64'(frame_cnt), 64'd2);
        chk("simul_word_cnt", 64'(word_cnt), 64'd2);
        drain("simul", 100);

        // random frames under 50% backpressure
        bp_mode = 2;
        src_pct = 90;
        for (int f = 0; f < 1000; f++) begin
            push_frame($urandom_range(1, 40), 3'($urandom));
            while (stim.size() > 40) step();
        end
        drain("rand", 3000);

        // reset mid-frame with 20 words stored
        bp_mode = 1;
        src_pct = 100;
        push_frame(40, 3'd0);
        fill_to("midrst", 20, 100);
        RESET_N = 1'b0;
        stim.delete();
        rx_if.SRC_RDY_N = 1'b1;
        #1;
        chk("midrst_word_cnt", 64'(word_cnt), 64'd0);
        chk("midrst_tx_src_rdy_n", 64'(tx_if.SRC_RDY_N), 64'd1);
        chk("midrst_rx_dst_rdy_n", 64'(rx_if.DST_RDY_N), 64'd1);
        step();
        RESET_N = 1'b1;
        step();
        chk("midrst_rel_rx_dst_rdy_n", 64'(rx_if.DST_RDY_N), 64'd0);
        push_frame(5, 3'd7);
        bp_mode = 0;
        drain("midrst", 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/fl_pac_fifo.md
FL_PAC_FIFO -- requirements
Module: fl_pac_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 64, FrameLink data width in bits (64 or 128).
REQ-002 Parameter DEPTH, default 64, storage capacity in words (power of 2, at least 8).
REQ-003 Derived REM_WIDTH = log2(DATA_WIDTH/8); CNT_WIDTH = log2(DEPTH)+1.
REQ-004 CLK  in  1  sole clock; all state changes on rising edge.
REQ-005 RESET_N  in  1  asynchronous, active-low reset.
REQ-006 RX_DATA / RX_REM  in  DATA_WIDTH / REM_WIDTH  input word and valid-byte index; driven by the SW TX buffer (packet variant) FrameLink output.
REQ-007 RX_SOF_N, RX_SOP_N, RX_EOP_N, RX_EOF_N  in  1 each  frame/part delimiters, active low.
REQ-008 RX_SRC_RDY_N  in  1 / RX_DST_RDY_N  out  1  input handshake, active low.
REQ-009 TX_DATA, TX_REM, TX_SOF_N, TX_SOP_N, TX_EOP_N, TX_EOF_N  out  same widths  output word and delimiters.
REQ-010 TX_SRC_RDY_N  out  1 / TX_DST_RDY_N  in  1  output handshake, active low.
REQ-011 FRAME_CNT  out  CNT_WIDTH  number of complete frames stored.
REQ-012 WORD_CNT  out  CNT_WIDTH  occupancy in words; EMPTY, FULL  out  1 each.

Function
REQ-013 Input word is accepted in a cycle where RX_SRC_RDY_N=0 and RX_DST_RDY_N=0; output word is transferred when TX_SRC_RDY_N=0 and TX_DST_RDY_N=0.
REQ-014 Each stored entry holds DATA, REM and four delimiters; the output reproduces them bit-exact, in order.
REQ-015 RX_DST_RDY_N is a register output: 1 when WORD_CNT=DEPTH, otherwise 0; no combinational path from RX_SRC_RDY_N.
REQ-016 Write and read pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-017 WORD_CNT: +1 on accept only, -1 on transfer only, unchanged on both; EMPTY = (WORD_CNT=0), FULL = (WORD_CNT=DEPTH).
REQ-018 FRAME_CNT: +1 on accepting a word with RX_EOF_N=0, -1 on transferring a word with TX_EOF_N=0, unchanged when both happen in one cycle.
REQ-019 Store-and-forward mode (state SAF): TX_SRC_RDY_N=0 if and only if FRAME_CNT>0.
REQ-020 Cut-through state (state CT): entered from SAF when FULL=1 and FRAME_CNT=0 (frame larger than DEPTH); in CT, TX_SRC_RDY_N=0 if and only if WORD_CNT>0.
REQ-021 CT returns to SAF in the cycle after a transfer with TX_EOF_N=0.
REQ-022 Latency: a frame whose EOF word is accepted in cycle n gives TX_SRC_RDY_N=0 in cycle n+1 at the earliest, with its SOF word on TX.
REQ-023 TX outputs present the head-of-queue word whenever WORD_CNT>0 (first-word fall-through); they hold stable while TX_SRC_RDY_N=0 and TX_DST_RDY_N=1.
REQ-024 When DEPTH-1 words are stored and one word is transferred while one is accepted in the same cycle, WORD_CNT stays DEPTH-1 and no data is lost.
REQ-025 Input is assumed FrameLink-compliant; the block performs no delimiter checking.

Reset
REQ-026 While RESET_N=0: pointers, WORD_CNT and FRAME_CNT = 0; state = SAF; EMPTY=1; FULL=0; TX_SRC_RDY_N=1; RX_DST_RDY_N=1.
REQ-027 In the first clock edge after RESET_N rises, RX_DST_RDY_N goes to 0; storage contents need no reset.
REQ-028 Reset asserted mid-frame discards all stored and partial frames; the next accepted word is treated as start of stream.

Verification
REQ-029 Single 3-word frame (SOF+SOP on word 0, EOP+EOF on word 2, REM=5), TX_DST_RDY_N=0 -> TX_SRC_RDY_N stays 1 until the cycle after word 2 is accepted; 3 identical words out back-to-back; FRAME_CNT goes 1 then 0.
REQ-030 With DEPTH=64, write 64 words of 8-word frames with TX_DST_RDY_N=1 -> FULL=1, RX_DST_RDY_N=1, FRAME_CNT=8; one TX transfer -> RX_DST_RDY_N=0 next cycle.
REQ-031 A 100-word frame with DEPTH=64 -> at WORD_CNT=64 with FRAME_CNT=0, enter CT; all 100 words emerge in order; return to SAF after EOF transfer.
REQ-032 Simultaneous EOF accept and EOF transfer with FRAME_CNT=2 -> FRAME_CNT stays 2; WORD_CNT unchanged.
REQ-033 Random TX_DST_RDY_N backpressure (50%) over 1000 random frames of 1-40 words -> scoreboard match of every word, REM and delimiter; no TX change while stalled.
REQ-034 RESET_N pulsed low mid-frame with 20 words stored -> WORD_CNT=0, TX_SRC_RDY_N=1 immediately; the next clean frame passes correctly.
